// File: rtl/spi_adc_pkg.sv
// Shared types, SPI mode constants and channel-search helper for the SPI ADC scan controller.
package spi_adc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StShift,
      StQuiet
   } state_e;

   localparam bit          CPOL      = 1'b0;
   localparam bit          MSB_FIRST = 1'b1;
   localparam int unsigned MAX_CH    = 16;

   // Lowest set bit of mask at or above index 'from'; -1 when there is none.
   function automatic int find_set(input logic [MAX_CH-1:0] mask, input int from);
      int r;
      r = -1;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (i >= from && mask[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Counter-based SCLK divider: CLK_DIV clk cycles per half-period, rise/fall strobes, rise count.
module spi_sclk_gen
   import spi_adc_pkg::*;
#(
   parameter int unsigned CLK_DIV = 5,
   parameter int unsigned DATA_W  = 18,
   parameter int unsigned BIT_W   = $clog2(DATA_W + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic             sclk,
   output logic             rise,
   output logic             fall,
   output logic [BIT_W-1:0] bit_cnt
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] div_q;
   logic             half_end;

   // Strobes flag the edge on which sclk toggles, so the toggle and the strobe coincide.
   assign half_end = en && (div_q == DIV_W'(CLK_DIV - 1));
   assign rise     = half_end && (sclk == CPOL);
   assign fall     = half_end && (sclk != CPOL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         sclk    <= CPOL;
         bit_cnt <= '0;
      end else if (!en) begin
         div_q   <= '0;
         sclk    <= CPOL;
         bit_cnt <= '0;
      end else begin
         div_q <= half_end ? '0 : div_q + 1'b1;
         if (half_end) sclk <= ~sclk;
         if (rise) bit_cnt <= bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_adc_scan_controller.sv
// Multi-chip SPI ADC scanner: walks the enabled chip-selects, shifts DATA_W bits from each
// chip and presents channel-tagged samples on a valid/ready output with sticky overrun.
module spi_adc_scan_controller
   import spi_adc_pkg::*;
#(
   parameter int unsigned DATA_W   = 18,
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int unsigned CLK_DIV  = 5,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_QUIET = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              miso,
   output logic [NUM_CH-1:0] cs_n,
   output logic              sclk,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned BIT_W   = $clog2(DATA_W + 1);
   localparam int unsigned CNT_MAX = (CS_SETUP > CS_QUIET) ? CS_SETUP : CS_QUIET;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_e            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [NUM_CH-1:0] mask_q, mask_d, cs_n_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q;
   logic [BIT_W-1:0]  bit_cnt;
   logic              rise, fall, done, accept, drop;
   int                nxt;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV),
      .DATA_W  (DATA_W),
      .BIT_W   (BIT_W)
   ) u_sclk_gen (
      .clk     (clk),
      .reset   (reset),
      .en      (state_q == StShift),
      .sclk    (sclk),
      .rise    (rise),
      .fall    (fall),
      .bit_cnt (bit_cnt)
   );

   assign done   = fall && (bit_cnt == BIT_W'(DATA_W));
   assign accept = (state_q == StIdle) && start && (|ch_enable);
   assign drop   = done && out_valid && !out_ready;
   assign busy   = (state_q != StIdle);

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      nxt     = -1;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               mask_d  = ch_enable;
               nxt     = find_set(MAX_CH'(ch_enable), 0);
               state_d = StSetup;
               cnt_d   = '0;
            end
         end
         StSetup: begin
            if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
               state_d = StShift;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StShift: begin
            if (done) state_d = StQuiet;
         end
         StQuiet: begin
            if (cnt_q == CNT_W'(CS_QUIET - 1)) begin
               cnt_d = '0;
               nxt   = find_set(MAX_CH'(mask_q), int'(ch_q) + 1);
               if (nxt >= 0) begin
                  state_d = StSetup;
               end else if (continuous && |ch_enable) begin
                  // Rescan picks up whatever mask is enabled now.
                  mask_d  = ch_enable;
                  nxt     = find_set(MAX_CH'(ch_enable), 0);
                  state_d = StSetup;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (nxt >= 0) ch_d = CH_W'(nxt);

      cs_n_d = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((state_d == StSetup || state_d == StShift) && ch_d == CH_W'(i)) cs_n_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         ch_q      <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         cs_n      <= '1;
         shreg_q   <= '0;
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         cs_n    <= cs_n_d;
         if (rise) begin
            shreg_q <= MSB_FIRST ? {shreg_q[DATA_W-2:0], miso} : {miso, shreg_q[DATA_W-1:1]};
         end
         if (done && !drop) begin
            out_data  <= shreg_q;
            out_ch    <= ch_q;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop) overrun <= 1'b1;
         else if (accept) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_adc_scan_controller.sv
// Directed bench for spi_adc_scan_controller: default build plus an 8-bit, single-chip build.
module tb_spi_adc_scan_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, continuous, out_ready, miso;
   logic [3:0]  ch_enable, cs_n;
   logic        sclk, out_valid, busy, overrun;
   logic [17:0] out_data;
   logic [1:0]  out_ch;

   logic        start2, miso2, sclk2, out_valid2, busy2, overrun2;
   logic [0:0]  ch_en2, cs_n2, out_ch2;
   logic [7:0]  out_data2;

   logic [17:0] pat [4];
   logic [7:0]  pat2;
   int          idx, idx2;
   logic        cs_hi, cs_hi2;

   int          n_checks = 0;
   int          n_bad = 0;
   int          total_low [4] = '{0, 0, 0, 0};
   int          multi_low = 0;
   int          n_samp = 0;
   logic [17:0] samp_data [64];
   logic [1:0]  samp_ch [64];

   always #5 clk = ~clk;

   spi_adc_scan_controller dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .continuous (continuous),
      .ch_enable  (ch_enable),
      .miso       (miso),
      .cs_n       (cs_n),
      .sclk       (sclk),
      .out_data   (out_data),
      .out_ch     (out_ch),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .overrun    (overrun)
   );

   spi_adc_scan_controller #(
      .DATA_W  (8),
      .NUM_CH  (1),
      .CLK_DIV (2)
   ) dut_small (
      .clk        (clk),
      .reset      (reset),
      .start      (start2),
      .continuous (1'b0),
      .ch_enable  (ch_en2),
      .miso       (miso2),
      .cs_n       (cs_n2),
      .sclk       (sclk2),
      .out_data   (out_data2),
      .out_ch     (out_ch2),
      .out_valid  (out_valid2),
      .out_ready  (1'b1),
      .busy       (busy2),
      .overrun    (overrun2)
   );

   // ADC models: MSB first, next bit presented after every sclk rise, restart when deselected.
   assign cs_hi  = &cs_n;
   assign cs_hi2 = cs_n2[0];

   always @(posedge sclk or posedge cs_hi) begin
      if (cs_hi) idx <= 0;
      else idx <= idx + 1;
   end

   always @(posedge sclk2 or posedge cs_hi2) begin
      if (cs_hi2) idx2 <= 0;
      else idx2 <= idx2 + 1;
   end

   always_comb begin
      miso = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!cs_n[i] && idx < 18) miso = pat[i][17-idx];
      end
   end

   always_comb begin
      miso2 = 1'b0;
      if (!cs_n2[0] && idx2 < 8) miso2 = pat2[7-idx2];
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!cs_n[i]) total_low[i] <= total_low[i] + 1;
      end
      if ($countones(~cs_n) > 1) multi_low <= multi_low + 1;
      if (out_valid && out_ready && n_samp < 64) begin
         samp_data[n_samp] <= out_data;
         samp_ch[n_samp]   <= out_ch;
         n_samp            <= n_samp + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Waits for cs_n[ch] to fall, then measures the low window; returns at the negedge after it rises.
   task automatic run_conv(input int ch, input int drop_at, output int gap, output int low,
                           output int rises);
      int   budget;
      logic prev;
      gap = 0; low = 0; rises = 0; budget = 0;
      while (cs_n[ch] && budget < 3000) begin
         @(negedge clk);
         gap++; budget++;
      end
      prev = sclk;
      while (!cs_n[ch] && budget < 3000) begin
         low++;
         if (low == drop_at) continuous = 1'b0;
         @(negedge clk);
         budget++;
         if (sclk && !prev) rises++;
         prev = sclk;
      end
      check("conv_timeout", 32'(budget >= 3000), 32'(0));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gap, low, rises, s0, l0, l2, r;
      reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_enable = 4'b0; out_ready = 1'b1;
      start2 = 1'b0; ch_en2 = 1'b0; pat2 = 8'h00;
      for (int i = 0; i < 4; i++) pat[i] = 18'h0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", 32'(cs_n), 32'hF);
      check("rst_sclk", 32'(sclk), 32'(0));
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_data", 32'(out_data), 32'(0));
      check("rst_ch", 32'(out_ch), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      check("rst_small_cs_n", 32'(cs_n2), 32'(1));
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single conversion on chip 0
      pat[0] = 18'h2A5C3; ch_enable = 4'b0001;
      pulse_start();
      check("t1_busy_start", 32'(busy), 32'(1));
      run_conv(0, -1, gap, low, rises);
      check("t1_low_len", 32'(low), 32'(182));
      check("t1_rises", 32'(rises), 32'(18));
      check("t1_valid", 32'(out_valid), 32'(1));
      check("t1_data", 32'(out_data), 32'h2A5C3);
      check("t1_ch", 32'(out_ch), 32'(0));
      repeat (3) @(negedge clk);
      check("t1_busy_quiet", 32'(busy), 32'(1));
      @(negedge clk);
      check("t1_busy_idle", 32'(busy), 32'(0));
      check("t1_valid_cleared", 32'(out_valid), 32'(0));

      // 2: scan chips 1 and 3
      pat[1] = 18'h1F00F; pat[3] = 18'h3C3C3; ch_enable = 4'b1010;
      s0 = n_samp; l0 = total_low[0]; l2 = total_low[2];
      pulse_start();
      run_conv(1, -1, gap, low, rises);
      check("t2_ch1_data", 32'(out_data), 32'h1F00F);
      check("t2_ch1_ch", 32'(out_ch), 32'(1));
      run_conv(3, -1, gap, low, rises);
      check("t2_gap", 32'(gap), 32'(4));
      check("t2_ch3_data", 32'(out_data), 32'h3C3C3);
      check("t2_ch3_ch", 32'(out_ch), 32'(3));
      wait_idle();
      check("t2_nsamp", 32'(n_samp - s0), 32'(2));
      check("t2_samp0", 32'({samp_ch[s0], samp_data[s0]}), 32'({2'd1, 18'h1F00F}));
      check("t2_samp1", 32'({samp_ch[s0+1], samp_data[s0+1]}), 32'({2'd3, 18'h3C3C3}));
      check("t2_ch0_idle", 32'(total_low[0] - l0), 32'(0));
      check("t2_ch2_idle", 32'(total_low[2] - l2), 32'(0));

      // 3: continuous on chip 0, then drop continuous mid-SHIFT of the third conversion
      pat[0] = 18'h15555; ch_enable = 4'b0001; continuous = 1'b1;
      pulse_start();
      run_conv(0, -1, gap, low, rises);
      check("t3_data0", 32'(out_data), 32'h15555);
      run_conv(0, -1, gap, low, rises);
      check("t3_period", 32'(gap + low), 32'(186));
      run_conv(0, 50, gap, low, rises);
      check("t3_last_low", 32'(low), 32'(182));
      check("t3_last_data", 32'(out_data), 32'h15555);
      wait_idle();
      l0 = total_low[0];
      repeat (20) @(negedge clk);
      check("t3_stopped", 32'(total_low[0] - l0), 32'(0));

      // 4: overrun with out_ready low, zero-mask start, start while busy
      pat[0] = 18'h00ABC; pat[1] = 18'h3FFFF; ch_enable = 4'b0011; out_ready = 1'b0;
      pulse_start();
      run_conv(0, -1, gap, low, rises);
      check("t4_first_data", 32'(out_data), 32'h00ABC);
      check("t4_no_overrun", 32'(overrun), 32'(0));
      run_conv(1, -1, gap, low, rises);
      check("t4_overrun", 32'(overrun), 32'(1));
      check("t4_held_data", 32'(out_data), 32'h00ABC);
      check("t4_held_ch", 32'(out_ch), 32'(0));
      check("t4_held_valid", 32'(out_valid), 32'(1));
      wait_idle();
      ch_enable = 4'b0000;
      l0 = total_low[0] + total_low[1] + total_low[2] + total_low[3];
      pulse_start();
      check("t4_zero_busy", 32'(busy), 32'(0));
      repeat (10) @(negedge clk);
      check("t4_zero_no_cs", 32'(total_low[0] + total_low[1] + total_low[2] + total_low[3] - l0),
            32'(0));
      check("t4_zero_keeps_overrun", 32'(overrun), 32'(1));
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_drain", 32'(out_valid), 32'(0));
      pat[0] = 18'h12345; ch_enable = 4'b0001;
      pulse_start();
      check("t4_overrun_cleared", 32'(overrun), 32'(0));
      s0 = n_samp; l2 = total_low[2];
      repeat (20) @(negedge clk);
      ch_enable = 4'b0100;
      pulse_start();
      run_conv(0, -1, gap, low, rises);
      check("t4_busy_start_data", 32'(out_data), 32'h12345);
      wait_idle();
      repeat (2) @(negedge clk);
      check("t4_busy_start_nsamp", 32'(n_samp - s0), 32'(1));
      check("t4_busy_start_ch2", 32'(total_low[2] - l2), 32'(0));

      // 5: asynchronous reset mid-SHIFT
      pat[0] = 18'h0F0F0; ch_enable = 4'b0001; out_ready = 1'b0;
      pulse_start();
      run_conv(0, -1, gap, low, rises);
      wait_idle();
      pulse_start();
      r = 0; gap = 0; rises = 0;
      while (r < 7 && gap < 1000) begin
         @(negedge clk);
         gap++;
         if (sclk && !rises[0]) r++;
         rises = 32'(sclk);
      end
      repeat (2) @(negedge clk);
      check("t5_pre_sclk", 32'(sclk), 32'(1));
      check("t5_pre_valid", 32'(out_valid), 32'(1));
      reset = 1'b1;
      #1;
      check("t5_rst_cs_n", 32'(cs_n), 32'hF);
      check("t5_rst_sclk", 32'(sclk), 32'(0));
      check("t5_rst_valid", 32'(out_valid), 32'(0));
      check("t5_rst_data", 32'(out_data), 32'(0));
      check("t5_rst_busy", 32'(busy), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0; out_ready = 1'b1; pat[0] = 18'h2A5C3;
      pulse_start();
      run_conv(0, -1, gap, low, rises);
      check("t5_low_len", 32'(low), 32'(182));
      check("t5_rises", 32'(rises), 32'(18));
      check("t5_data", 32'(out_data), 32'h2A5C3);
      wait_idle();

      // 6: 8-bit, CLK_DIV=2, single-chip build
      pat2 = 8'hC6; ch_en2 = 1'b1;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      low = 0; rises = 0; gap = 0; r = 0;
      while (!cs_n2[0] && gap < 500) begin
         low++;
         @(negedge clk);
         gap++;
         if (sclk2 && !r[0]) rises++;
         r = 32'(sclk2);
      end
      check("t6_low_len", 32'(low), 32'(34));
      check("t6_rises", 32'(rises), 32'(8));
      check("t6_valid", 32'(out_valid2), 32'(1));
      check("t6_data", 32'(out_data2), 32'hC6);
      check("t6_ch", 32'(out_ch2), 32'(0));

      check("one_cs_low", 32'(multi_low), 32'(0));
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
